// File: rtl/sprite_collision_core.sv
// rtl/sprite_collision_core.sv - zero-latency pixel pass-through with per-frame box/colour collision counting
// Counts target-coloured pixels inside a programmed box and latches the results at each start of frame.
module sprite_collision_core #(
  parameter int            CD        = 12,
  parameter logic [CD-1:0] HIT_COLOR = 12'hF00,
  parameter int            H_VISIBLE = 640,
  parameter int            V_VISIBLE = 480
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [10:0]   x,
  input  logic [10:0]   y,
  input  logic          cs,
  input  logic          write,
  input  logic          read,
  input  logic [13:0]   addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data,
  input  logic [CD-1:0] si_rgb,
  output logic [CD-1:0] so_rgb
);

  localparam logic [10:0] H_VIS = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS = 11'(V_VISIBLE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COUNT = 2'd2
  } state_t;

  state_t        state_q;
  logic          enable_q;
  logic          highlight_q;
  logic [10:0]   bx0_q, by0_q, bx1_q, by1_q;
  logic [CD-1:0] target_q;
  logic [10:0]   x_q, y_q;
  logic [19:0]   run_hits_q;
  logic [19:0]   last_hits_q;
  logic          coll_last_q;
  logic          sticky_q;
  logic [15:0]   coll_cnt_q;
  logic [15:0]   frame_cnt_q;

  logic          reg_wr;
  logic          clear;
  logic          pix_new;
  logic          sof;
  logic          in_vis;
  logic          in_box;
  logic          hit_comb;
  logic          hit;
  logic          frame_has_hit;
  logic [19:0]   run_hits_d;
  logic [15:0]   coll_cnt_d;
  logic          unused_bits;

  assign reg_wr = cs & write & addr[13];
  assign clear  = reg_wr & (addr[2:0] == 3'd0) & wr_data[2];

  // x/y may hold for several clocks per pixel, so only count on a coordinate change
  assign pix_new = (x != x_q) | (y != y_q);
  assign sof     = pix_new & (x == 11'd0) & (y == 11'd0);

  assign in_vis   = (x < H_VIS) & (y < V_VIS);
  assign in_box   = (x >= bx0_q) & (x <= bx1_q) & (y >= by0_q) & (y <= by1_q);
  assign hit_comb = (state_q == COUNT) & in_vis & in_box & (si_rgb == target_q);
  assign hit      = hit_comb & pix_new;

  assign frame_has_hit = (run_hits_q != 20'd0);
  assign run_hits_d    = (run_hits_q == 20'hFFFFF) ? run_hits_q : run_hits_q + 20'd1;
  assign coll_cnt_d    = (frame_has_hit && coll_cnt_q != 16'hFFFF) ? coll_cnt_q + 16'd1 : coll_cnt_q;

  assign so_rgb = (highlight_q & hit_comb) ? HIT_COLOR : si_rgb;

  assign unused_bits = &{1'b0, read, addr[12:3], wr_data[31:11]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q    <= 1'b0;
      highlight_q <= 1'b0;
      bx0_q       <= '0;
      by0_q       <= '0;
      bx1_q       <= '0;
      by1_q       <= '0;
      target_q    <= '0;
    end else if (reg_wr) begin
      case (addr[2:0])
        3'd0: begin
          enable_q    <= wr_data[0];
          highlight_q <= wr_data[1];
        end
        3'd1: bx0_q    <= wr_data[10:0];
        3'd2: by0_q    <= wr_data[10:0];
        3'd3: bx1_q    <= wr_data[10:0];
        3'd4: by1_q    <= wr_data[10:0];
        3'd5: target_q <= wr_data[CD-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      run_hits_q  <= '0;
      last_hits_q <= '0;
      coll_last_q <= 1'b0;
      sticky_q    <= 1'b0;
      coll_cnt_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      x_q <= x;
      y_q <= y;
      if (!enable_q) begin
        state_q    <= IDLE;
        run_hits_q <= '0;
      end else begin
        case (state_q)
          IDLE: state_q <= ARMED;
          // wait for a frame start so a partial frame is never reported
          ARMED: begin
            if (sof) begin
              state_q    <= COUNT;
              run_hits_q <= '0;
            end
          end
          COUNT: begin
            if (sof) begin
              last_hits_q <= run_hits_q;
              coll_last_q <= frame_has_hit;
              sticky_q    <= sticky_q | frame_has_hit;
              coll_cnt_q  <= coll_cnt_d;
              frame_cnt_q <= frame_cnt_q + 16'd1;
              run_hits_q  <= {19'b0, hit};
            end else if (hit) begin
              run_hits_q <= run_hits_d;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
      // clear is placed last so it overrides a coincident frame latch
      if (clear) begin
        last_hits_q <= '0;
        coll_last_q <= 1'b0;
        sticky_q    <= 1'b0;
        coll_cnt_q  <= '0;
        frame_cnt_q <= '0;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (addr[13]) begin
      case (addr[2:0])
        3'd0:    rd_data = {coll_cnt_q, 12'b0, state_q, sticky_q, coll_last_q};
        3'd1:    rd_data = {12'b0, last_hits_q};
        3'd2:    rd_data = {16'b0, frame_cnt_q};
        default: rd_data = '0;
      endcase
    end
  end

endmodule
